// File: rtl/cache_mem_ctrl.sv
// cache_mem_ctrl
// Memory-side controller below the direct-mapped write-through byte cache.
// It serves 32-bit block refills as four byte reads. Write-through bytes are
// posted into a small FIFO and drained in order. Pending writes always drain
// before a refill starts, so every refill sees the latest data.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   rreq_from_cache     refill request (level, held until rvalid_to_cache)
//   raddr_from_cache    refill byte address, bits [1:0] ignored
//   rdata_to_cache      assembled refill word, little-endian
//   rvalid_to_cache     one-cycle pulse, rdata_to_cache valid with it
//   wreq_from_cache     write-through pulse, one byte per cycle
//   waddr_from_cache    write byte address
//   wdata_from_cache    write byte
//   wbuf_empty/full     write-buffer occupancy flags
//   wbuf_overflow       sticky, set when a posted write had to be dropped
//   mem_en/we/addr/wdata  byte-wide synchronous RAM request
//   mem_rdata           RAM read byte, valid the cycle after a read access
//
// state   | meaning
// IDLE    | nothing in flight
// WR      | popping one buffered write per cycle into the RAM
// RD      | issuing refill beats 0..3
// RD_LAST | capturing byte 3, loading the refill word
// RESP    | rvalid_to_cache high for this single cycle
module cache_mem_ctrl #(
    parameter int ADDR_W     = 13,
    parameter int WBUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rreq_from_cache,
    input  logic [ADDR_W-1:0] raddr_from_cache,
    output logic [31:0]       rdata_to_cache,
    output logic              rvalid_to_cache,
    input  logic              wreq_from_cache,
    input  logic [ADDR_W-1:0] waddr_from_cache,
    input  logic [7:0]        wdata_from_cache,
    output logic              wbuf_empty,
    output logic              wbuf_full,
    output logic              wbuf_overflow,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {IDLE, WR, RD, RD_LAST, RESP} state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] fifo_addr [WBUF_DEPTH];
    logic [7:0]        fifo_data [WBUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count, count_next;
    logic              push, pop;

    logic [ADDR_W-3:0] word_addr;
    logic [1:0]        beat;
    logic              cap_en;
    logic [1:0]        cap_idx;
    logic [23:0]       asm_bytes;
    logic [ADDR_W-1:0] last_addr;
    logic [7:0]        last_wdata;

    logic unused_raddr_bits;
    assign unused_raddr_bits = ^raddr_from_cache[1:0];

    // ---------------- write buffer ----------------
    assign pop        = (state == WR) && (count != '0);
    // A full buffer still takes a write when the head leaves in the same cycle.
    assign push       = wreq_from_cache && ((count < CNT_W'(WBUF_DEPTH)) || pop);
    assign wbuf_empty = (count == '0);
    assign wbuf_full  = (count == CNT_W'(WBUF_DEPTH));

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + CNT_W'(1);
        else if (!push && pop)
            count_next = count - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            wbuf_overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
            if (wreq_from_cache && !push)
                wbuf_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= waddr_from_cache;
            fifo_data[wr_ptr] <= wdata_from_cache;
        end
    end

    // ---------------- state machine ----------------
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // A write arriving in IDLE counts as pending, so a simultaneous refill
    // still observes it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if ((count != '0) || push)
                    state_next = WR;
                else if (rreq_from_cache)
                    state_next = RD;
            end
            WR: begin
                if (count_next != '0)
                    state_next = WR;
                else if (rreq_from_cache)
                    state_next = RD;
                else
                    state_next = IDLE;
            end
            RD:      state_next = (beat == 2'd3) ? RD_LAST : RD;
            RD_LAST: state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // RAM request decoded from the registered state; address/data hold
    // their last driven values while idle.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = last_addr;
        mem_wdata = last_wdata;
        case (state)
            WR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = fifo_addr[rd_ptr];
                mem_wdata = fifo_data[rd_ptr];
            end
            RD: begin
                mem_en   = 1'b1;
                mem_addr = {word_addr, beat};
            end
            default: ;
        endcase
    end

    // ---------------- refill datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            word_addr       <= '0;
            beat            <= 2'd0;
            cap_en          <= 1'b0;
            cap_idx         <= 2'd0;
            asm_bytes       <= '0;
            rdata_to_cache  <= '0;
            rvalid_to_cache <= 1'b0;
            last_addr       <= '0;
            last_wdata      <= '0;
        end else begin
            if ((state_next == RD) && (state != RD)) begin
                word_addr <= raddr_from_cache[ADDR_W-1:2];
                beat      <= 2'd0;
            end else if (state == RD) begin
                beat <= beat + 2'd1;
            end

            // RAM data returns one cycle after the beat, so remember which
            // byte lane the returning data belongs to.
            cap_en  <= (state == RD);
            cap_idx <= beat;
            if (cap_en) begin
                case (cap_idx)
                    2'd0:    asm_bytes[7:0]   <= mem_rdata;
                    2'd1:    asm_bytes[15:8]  <= mem_rdata;
                    2'd2:    asm_bytes[23:16] <= mem_rdata;
                    default: ;
                endcase
            end

            rvalid_to_cache <= (state == RD_LAST);
            if (state == RD_LAST)
                rdata_to_cache <= {mem_rdata, asm_bytes};

            if (mem_en) begin
                last_addr  <= mem_addr;
                last_wdata <= mem_wdata;
            end
        end
    end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
module tb_cache_mem_ctrl;

    localparam int ADDR_W = 13;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              rreq_from_cache = 1'b0;
    logic [ADDR_W-1:0] raddr_from_cache = '0;
    logic [31:0]       rdata_to_cache;
    logic              rvalid_to_cache;
    logic              wreq_from_cache = 1'b0;
    logic [ADDR_W-1:0] waddr_from_cache = '0;
    logic [7:0]        wdata_from_cache = '0;
    logic              wbuf_empty, wbuf_full, wbuf_overflow;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    cache_mem_ctrl #(.ADDR_W(ADDR_W), .WBUF_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .rreq_from_cache(rreq_from_cache), .raddr_from_cache(raddr_from_cache),
        .rdata_to_cache(rdata_to_cache), .rvalid_to_cache(rvalid_to_cache),
        .wreq_from_cache(wreq_from_cache), .waddr_from_cache(waddr_from_cache),
        .wdata_from_cache(wdata_from_cache),
        .wbuf_empty(wbuf_empty), .wbuf_full(wbuf_full), .wbuf_overflow(wbuf_overflow),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM written by the DUT; shadow is the bench's own expectation of contents.
    logic [7:0] ram    [0:(1<<ADDR_W)-1];
    logic [7:0] shadow [0:(1<<ADDR_W)-1];
    logic [7:0] rdata_q = 8'h00;
    assign mem_rdata = rdata_q;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        rdata_q <= ram[mem_addr];
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [7:0]        d;
    } wr_t;
    wr_t         exp_wq[$];
    logic [31:0] exp_rq[$];

    // Every RAM write must match the next expected write, in order.
    always @(negedge clk) begin
        if (!reset && mem_en && mem_we) begin
            wr_t e;
            checks++;
            if (exp_wq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write", mem_addr, mem_wdata);
            end else begin
                e = exp_wq.pop_front();
                if (mem_addr !== e.a || mem_wdata !== e.d) begin
                    errors++;
                    $display("FAIL write_order: got addr=%h data=%h, required addr=%h data=%h",
                             mem_addr, mem_wdata, e.a, e.d);
                end
            end
        end
    end

    task automatic post_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        exp_wq.push_back('{a, d});
        shadow[a] = d;
    endtask

    function automatic logic [31:0] word_of(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] b;
        b = {a[ADDR_W-1:2], 2'b00};
        return {shadow[b+3], shadow[b+2], shadow[b+1], shadow[b]};
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        rreq_from_cache = 1'b0;
        wreq_from_cache = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({rdata_to_cache, rvalid_to_cache, wbuf_overflow} !== 34'h0) begin
            errors++;
            $display("FAIL reset_resp: got rdata=%h rvalid=%b ovf=%b, required 0 0 0",
                     rdata_to_cache, rvalid_to_cache, wbuf_overflow);
        end
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_mem: got en=%b we=%b addr=%h wdata=%h, required all 0",
                     mem_en, mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if (wbuf_empty !== 1'b1 || wbuf_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_wbuf: got empty=%b full=%b, required 1 0", wbuf_empty, wbuf_full);
        end
        reset = 1'b0;
    endtask

    // Refill at address a; optionally posts a write in the same cycle as the request.
    task automatic run_refill(input logic [ADDR_W-1:0] a, input bit with_write,
                              input logic [ADDR_W-1:0] wa, input logic [7:0] wd);
        logic [ADDR_W-1:0] base;
        int nb, t0;
        bit done;
        base = {a[ADDR_W-1:2], 2'b00};
        nb = 0; t0 = 0; done = 0;
        @(negedge clk);
        rreq_from_cache  = 1'b1;
        raddr_from_cache = a;
        if (with_write) begin
            wreq_from_cache  = 1'b1;
            waddr_from_cache = wa;
            wdata_from_cache = wd;
            post_write(wa, wd);
        end
        exp_rq.push_back(word_of(a));
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            wreq_from_cache = 1'b0;
            if (mem_en && !mem_we) begin
                if (nb == 0) begin
                    t0 = cyc;
                    if (with_write) begin
                        checks++;
                        if (exp_wq.size() != 0) begin
                            errors++;
                            $display("FAIL write_before_read: got %0d writes pending at beat 0, required 0", exp_wq.size());
                        end
                    end
                end
                checks++;
                if (mem_addr !== ADDR_W'(base + nb)) begin
                    errors++;
                    $display("FAIL beat_addr: got %h, required %h", mem_addr, ADDR_W'(base + nb));
                end
                nb++;
            end
            if (rvalid_to_cache) begin
                logic [31:0] ew;
                done = 1;
                ew = exp_rq.pop_front();
                checks++;
                if (cyc - t0 != 5 || nb != 4) begin
                    errors++;
                    $display("FAIL read_latency: got %0d cycles %0d beats, required 5 cycles 4 beats", cyc - t0, nb);
                end
                checks++;
                if (rdata_to_cache !== ew) begin
                    errors++;
                    $display("FAIL refill_data: got %h, required %h", rdata_to_cache, ew);
                end
                rreq_from_cache = 1'b0;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL refill_timeout: got no rvalid, required rvalid within 30 cycles");
        end
        @(negedge clk);
        checks++;
        if (rvalid_to_cache !== 1'b0) begin
            errors++;
            $display("FAIL rvalid_pulse: got %b one cycle later, required 0", rvalid_to_cache);
        end
    endtask

    task automatic test_refill();
        run_refill(13'h0106, 1'b0, '0, '0);
    endtask

    task automatic test_write_single();
        @(negedge clk);
        wreq_from_cache  = 1'b1;
        waddr_from_cache = 13'h0010;
        wdata_from_cache = 8'hAB;
        post_write(13'h0010, 8'hAB);
        @(negedge clk);
        wreq_from_cache = 1'b0;
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 13'h0010, 8'hAB}) begin
            errors++;
            $display("FAIL single_write: got en=%b we=%b addr=%h data=%h, required 1 1 0010 ab",
                     mem_en, mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        checks++;
        if (wbuf_empty !== 1'b1 || mem_en !== 1'b0 || mem_addr !== 13'h0010) begin
            errors++;
            $display("FAIL after_write: got empty=%b en=%b addr=%h, required 1 0 0010",
                     wbuf_empty, mem_en, mem_addr);
        end
    endtask

    task automatic test_write_then_read();
        run_refill(13'h0104, 1'b1, 13'h0105, 8'h5A);
        checks++;
        if (word_of(13'h0104) !== 32'h44335A11) begin
            errors++;
            $display("FAIL shadow_word: got %h, required 44335a11", word_of(13'h0104));
        end
    endtask

    // Starts a refill and waits for its first beat; returns with rreq held high.
    task automatic start_refill_to_beat0(input logic [ADDR_W-1:0] a, output bit ok);
        ok = 0;
        @(negedge clk);
        rreq_from_cache  = 1'b1;
        raddr_from_cache = a;
        exp_rq.push_back(word_of(a));
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (mem_en && !mem_we) ok = 1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL beat0_timeout: got no read beat, required one within 20 cycles");
        end
    endtask

    task automatic wait_rvalid_and_check();
        bit done;
        logic [31:0] ew;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (rvalid_to_cache) done = 1;
            else @(negedge clk);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL rvalid_timeout: got no rvalid, required rvalid within 20 cycles");
        end else begin
            ew = exp_rq.pop_front();
            if (rdata_to_cache !== ew) begin
                errors++;
                $display("FAIL refill_data_wr: got %h, required %h", rdata_to_cache, ew);
            end
        end
        rreq_from_cache = 1'b0;
    endtask

    task automatic wait_drained();
        bit done;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (wbuf_empty && !mem_en) done = 1;
        end
        checks++;
        if (!done || exp_wq.size() != 0) begin
            errors++;
            $display("FAIL drain: got empty=%b pending=%0d, required 1 0", wbuf_empty, exp_wq.size());
        end
    endtask

    task automatic test_overflow();
        bit ok;
        start_refill_to_beat0(13'h0200, ok);
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin
                checks++;
                if (wbuf_full !== 1'b1 || wbuf_overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL full_after4: got full=%b ovf=%b, required 1 0", wbuf_full, wbuf_overflow);
                end
            end
            wreq_from_cache  = 1'b1;
            waddr_from_cache = ADDR_W'(13'h0300 + k);
            wdata_from_cache = 8'(8'hC0 + k);
            if (k < 4) post_write(ADDR_W'(13'h0300 + k), 8'(8'hC0 + k));
            @(negedge clk);
        end
        wreq_from_cache = 1'b0;
        checks++;
        if (wbuf_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set: got %b, required 1", wbuf_overflow);
        end
        wait_rvalid_and_check();
        wait_drained();
        checks++;
        if (wbuf_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: got %b, required 1", wbuf_overflow);
        end
    endtask

    task automatic test_full_pop();
        bit ok, seen;
        start_refill_to_beat0(13'h0400, ok);
        for (int k = 0; k < 4; k++) begin
            wreq_from_cache  = 1'b1;
            waddr_from_cache = ADDR_W'(13'h0310 + k);
            wdata_from_cache = 8'(8'h90 + k);
            post_write(ADDR_W'(13'h0310 + k), 8'(8'h90 + k));
            @(negedge clk);
        end
        wreq_from_cache = 1'b0;
        wait_rvalid_and_check();
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (mem_en && mem_we) seen = 1;
        end
        checks++;
        if (!seen || wbuf_full !== 1'b1) begin
            errors++;
            $display("FAIL full_in_wr: got seen=%b full=%b, required 1 1", seen, wbuf_full);
        end
        wreq_from_cache  = 1'b1;
        waddr_from_cache = 13'h0320;
        wdata_from_cache = 8'h77;
        post_write(13'h0320, 8'h77);
        @(negedge clk);
        wreq_from_cache = 1'b0;
        checks++;
        if (wbuf_overflow !== 1'b0) begin
            errors++;
            $display("FAIL pop_push_ovf: got %b, required 0", wbuf_overflow);
        end
        wait_drained();
    endtask

    task automatic test_reset_mid_read();
        bit hit, pulse;
        hit = 0; pulse = 0;
        @(negedge clk);
        rreq_from_cache  = 1'b1;
        raddr_from_cache = 13'h0104;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (mem_en && !mem_we && mem_addr == 13'h0106) hit = 1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL beat2_timeout: got no beat at 0106, required one");
        end
        reset = 1'b1;
        rreq_from_cache = 1'b0;
        @(negedge clk);
        checks++;
        if ({rdata_to_cache, rvalid_to_cache, wbuf_overflow, mem_en, mem_we, mem_addr, mem_wdata} !== '0
            || wbuf_empty !== 1'b1 || wbuf_full !== 1'b0) begin
            errors++;
            $display("FAIL midread_reset: got rdata=%h rv=%b en=%b addr=%h empty=%b, required all reset values",
                     rdata_to_cache, rvalid_to_cache, mem_en, mem_addr, wbuf_empty);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rvalid_to_cache) pulse = 1;
        end
        checks++;
        if (pulse) begin
            errors++;
            $display("FAIL abandoned_rvalid: got rvalid pulse, required none");
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            ram[i]    <= 8'(i * 7 + 3);
            shadow[i]  = 8'(i * 7 + 3);
        end
        ram[13'h0104] <= 8'h11; shadow[13'h0104] = 8'h11;
        ram[13'h0105] <= 8'h22; shadow[13'h0105] = 8'h22;
        ram[13'h0106] <= 8'h33; shadow[13'h0106] = 8'h33;
        ram[13'h0107] <= 8'h44; shadow[13'h0107] = 8'h44;

        test_reset();
        test_refill();
        test_write_single();
        test_write_then_read();
        test_overflow();
        apply_reset();
        test_full_pop();
        test_reset_mid_read();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
